// File: rtl/tdc_hit_stamper.sv
// TDC hit stamper: merges fine code with a free-running coarse counter, applies a
// dead-time window and queues stamps in a first-word-fall-through FIFO.
module tdc_hit_stamper #(
  parameter int COARSE_W    = 24,
  parameter int FINE_MAX    = 89,
  parameter int PIPE_LAT    = 1,
  parameter int DEAD_CYCLES = 3,
  parameter int DEPTH       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [7:0]            fine_code,
  input  logic                  hit_strobe,
  output logic [COARSE_W+8:0]   ts_data,
  output logic                  ts_valid,
  input  logic                  ts_ready,
  output logic                  coarse_wrap,
  output logic [15:0]           drop_cnt,
  output logic                  fifo_full
);

  localparam int TW = COARSE_W + 9;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = $clog2(DEAD_CYCLES + 2);
  localparam logic [COARSE_W-1:0] PIPE_OFF = COARSE_W'(PIPE_LAT);
  localparam logic [7:0]          FINE_LIM = 8'(FINE_MAX);

  logic [COARSE_W-1:0] coarse;
  logic [DW-1:0]       dead;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic [TW-1:0]       mem [DEPTH];
  logic [TW-1:0]       stamp;
  logic                qual, push, pop, drop;

  assign qual = hit_strobe & en & (dead == '0);
  assign pop  = ts_valid & ts_ready;
  // A full FIFO still accepts a hit when the head leaves in the same cycle.
  assign push = qual & (~fifo_full | pop);
  assign drop = qual & ~push;

  always_comb begin
    stamp = '0;
    stamp[TW-2:8] = coarse - PIPE_OFF;
    if (fine_code > FINE_LIM) begin
      stamp[TW-1] = 1'b1;
      stamp[7:0]  = FINE_LIM;
    end else begin
      stamp[7:0]  = fine_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coarse      <= '0;
      coarse_wrap <= 1'b0;
    end else if (!en) begin
      coarse      <= '0;
      coarse_wrap <= 1'b0;
    end else begin
      coarse      <= coarse + 1'b1;
      coarse_wrap <= &coarse;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dead <= '0;
    else if (!en)
      dead <= '0;
    else if (qual)
      dead <= DW'(DEAD_CYCLES);
    else if (dead != '0)
      dead <= dead - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= stamp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (drop && drop_cnt != '1)
      drop_cnt <= drop_cnt + 1'b1;
  end

  assign ts_valid  = (count != '0);
  assign fifo_full = (count == (AW+1)'(DEPTH));
  assign ts_data   = ts_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_tdc_hit_stamper.sv
// Directed bench for tdc_hit_stamper: default build plus a COARSE_W=4 build for wrap checks.
module tb_tdc_hit_stamper;

  logic        clk = 1'b0;
  logic        rst_n, en, hit_strobe, ts_ready;
  logic [7:0]  fine_code;
  logic [32:0] ts_data;
  logic        ts_valid, coarse_wrap, fifo_full;
  logic [15:0] drop_cnt;

  logic        en4, hit4, ts_ready4;
  logic [7:0]  fine4;
  logic [12:0] ts_data4;
  logic        ts_valid4, coarse_wrap4, fifo_full4;
  logic [15:0] drop_cnt4;

  logic [23:0] exp_cnt;
  logic [3:0]  exp4;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tdc_hit_stamper dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fine_code(fine_code), .hit_strobe(hit_strobe),
    .ts_data(ts_data), .ts_valid(ts_valid), .ts_ready(ts_ready), .coarse_wrap(coarse_wrap),
    .drop_cnt(drop_cnt), .fifo_full(fifo_full)
  );

  tdc_hit_stamper #(.COARSE_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .fine_code(fine4), .hit_strobe(hit4),
    .ts_data(ts_data4), .ts_valid(ts_valid4), .ts_ready(ts_ready4), .coarse_wrap(coarse_wrap4),
    .drop_cnt(drop_cnt4), .fifo_full(fifo_full4)
  );

  // Advance one clock; the bench tracks the expected coarse counter value itself.
  task automatic tick();
    logic e, e4;
    e  = en;
    e4 = en4;
    @(posedge clk);
    exp_cnt = e  ? exp_cnt + 24'd1 : 24'd0;
    exp4    = e4 ? exp4 + 4'd1     : 4'd0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; hit_strobe = 1'b0; ts_ready = 1'b0; fine_code = '0;
    en4 = 1'b0; hit4 = 1'b0; ts_ready4 = 1'b0; fine4 = '0;
    exp_cnt = '0; exp4 = '0;
    #1;
    tests++;
    if ({ts_data, ts_valid, coarse_wrap, drop_cnt, fifo_full} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got data=%h valid=%b wrap=%b drop=%0d full=%b, want all 0",
               ts_data, ts_valid, coarse_wrap, drop_cnt, fifo_full);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    en = 1'b1;
  endtask

  task automatic test_single_hit();
    logic [32:0] exp;
    while (exp_cnt != 24'd100) tick();
    fine_code = 8'd37; hit_strobe = 1'b1;
    exp = {1'b0, 24'd99, 8'd37};
    tick();
    hit_strobe = 1'b0;
    tests++;
    if (ts_valid !== 1'b1) begin
      fails++; $display("FAIL single_valid: got %b, want 1", ts_valid);
    end
    tests++;
    if (ts_data !== exp) begin
      fails++; $display("FAIL single_data: got %h, want %h", ts_data, exp);
    end
    ts_ready = 1'b1; tick(); ts_ready = 1'b0;
    tests++;
    if (ts_valid !== 1'b0) begin
      fails++; $display("FAIL single_pop: valid got %b, want 0", ts_valid);
    end
    repeat (4) tick();
  endtask

  task automatic test_dead_time();
    logic [32:0] s0, s4;
    logic [7:0]  pattern;
    pattern = 8'b0001_1101;  // hits in relative cycles 0, 2, 3, 4
    for (int i = 0; i < 5; i++) begin
      hit_strobe = pattern[i];
      fine_code  = 8'(20 + i);
      if (i == 0) s0 = {1'b0, exp_cnt - 24'd1, 8'd20};
      if (i == 4) s4 = {1'b0, exp_cnt - 24'd1, 8'd24};
      tick();
    end
    hit_strobe = 1'b0;
    tests++;
    if (ts_data !== s0) begin
      fails++; $display("FAIL dead_first: got %h, want %h", ts_data, s0);
    end
    ts_ready = 1'b1; tick(); ts_ready = 1'b0;
    tests++;
    if (ts_data !== s4 || ts_valid !== 1'b1) begin
      fails++; $display("FAIL dead_second: got %h valid=%b, want %h valid=1", ts_data, ts_valid, s4);
    end
    ts_ready = 1'b1; tick(); ts_ready = 1'b0;
    tests++;
    if (ts_valid !== 1'b0 || drop_cnt !== 16'd0) begin
      fails++; $display("FAIL dead_drain: valid=%b drop=%0d, want valid=0 drop=0", ts_valid, drop_cnt);
    end
    repeat (4) tick();
  endtask

  task automatic test_fifo_full();
    logic [32:0] s [6];
    logic [32:0] want [4];
    logic [32:0] extra;
    for (int i = 0; i < 6; i++) begin
      fine_code  = 8'(10 + i);
      hit_strobe = 1'b1;
      s[i] = {1'b0, exp_cnt - 24'd1, 8'(10 + i)};
      tick();
      hit_strobe = 1'b0;
      if (i == 3) begin
        tests++;
        if (fifo_full !== 1'b1) begin
          fails++; $display("FAIL full_after_4: got %b, want 1", fifo_full);
        end
      end
      repeat (3) tick();
    end
    tests++;
    if (drop_cnt !== 16'd2) begin
      fails++; $display("FAIL full_drops: got %0d, want 2", drop_cnt);
    end
    tests++;
    if (ts_data !== s[0]) begin
      fails++; $display("FAIL full_head_stable: got %h, want %h", ts_data, s[0]);
    end
    // Hit and pop in the same cycle while full.
    fine_code = 8'd55; hit_strobe = 1'b1; ts_ready = 1'b1;
    extra = {1'b0, exp_cnt - 24'd1, 8'd55};
    tick();
    hit_strobe = 1'b0; ts_ready = 1'b0;
    tests++;
    if (fifo_full !== 1'b1 || drop_cnt !== 16'd2) begin
      fails++; $display("FAIL push_pop_full: full=%b drop=%0d, want full=1 drop=2", fifo_full, drop_cnt);
    end
    want[0] = s[1]; want[1] = s[2]; want[2] = s[3]; want[3] = extra;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (ts_data !== want[i] || ts_valid !== 1'b1) begin
        fails++; $display("FAIL drain_%0d: got %h valid=%b, want %h", i, ts_data, ts_valid, want[i]);
      end
      ts_ready = 1'b1; tick(); ts_ready = 1'b0;
    end
    tests++;
    if (ts_valid !== 1'b0) begin
      fails++; $display("FAIL drain_empty: valid got %b, want 0", ts_valid);
    end
    repeat (2) tick();
  endtask

  task automatic test_overrange();
    logic [32:0] exp;
    fine_code = 8'd120; hit_strobe = 1'b1;
    exp = {1'b1, exp_cnt - 24'd1, 8'd89};
    tick();
    hit_strobe = 1'b0;
    tests++;
    if (ts_data !== exp) begin
      fails++; $display("FAIL overrange: got %h, want %h", ts_data, exp);
    end
    ts_ready = 1'b1; tick(); ts_ready = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_disabled();
    en = 1'b0; fine_code = 8'd3; hit_strobe = 1'b1;
    tick(); tick();
    hit_strobe = 1'b0;
    tests++;
    if (ts_valid !== 1'b0 || drop_cnt !== 16'd2) begin
      fails++; $display("FAIL disabled_hit: valid=%b drop=%0d, want valid=0 drop=2", ts_valid, drop_cnt);
    end
    en = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    int pulses;
    int bad;
    logic [12:0] exp;
    pulses = 0; bad = 0;
    en4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (coarse_wrap4 === 1'b1) begin
        pulses++;
        if (exp4 != 4'd0) bad++;
      end
    end
    tests++;
    if (pulses != 1 || bad != 0) begin
      fails++; $display("FAIL wrap_pulse: got %0d pulses (%0d misplaced), want 1 at counter 0", pulses, bad);
    end
    for (int i = 0; i < 32 && exp4 != 4'd0; i++) tick();
    fine4 = 8'd5; hit4 = 1'b1;
    exp = {1'b0, 4'd15, 8'd5};
    tick();
    hit4 = 1'b0;
    tests++;
    if (ts_data4 !== exp) begin
      fails++; $display("FAIL wrap_hit_at_0: got %h, want %h", ts_data4, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [32:0] exp;
    for (int i = 0; i < 3; i++) begin
      fine_code = 8'(40 + i); hit_strobe = 1'b1;
      tick();
      hit_strobe = 1'b0;
      repeat (3) tick();
    end
    tests++;
    if (ts_valid !== 1'b1) begin
      fails++; $display("FAIL queued_before_reset: valid got %b, want 1", ts_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (ts_valid !== 1'b0 || drop_cnt !== 16'd0 || fifo_full !== 1'b0) begin
      fails++; $display("FAIL async_reset: valid=%b drop=%0d full=%b, want 0 0 0", ts_valid, drop_cnt, fifo_full);
    end
    en = 1'b0;
    @(posedge clk); #1;
    tick();
    rst_n = 1'b1;
    exp_cnt = '0;
    en = 1'b1;
    repeat (5) tick();
    fine_code = 8'd7; hit_strobe = 1'b1;
    exp = {1'b0, 24'd4, 8'd7};
    tick();
    hit_strobe = 1'b0;
    tests++;
    if (ts_data !== exp || drop_cnt !== 16'd0) begin
      fails++; $display("FAIL post_reset_hit: got %h drop=%0d, want %h drop=0", ts_data, drop_cnt, exp);
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_dead_time();
    test_fifo_full();
    test_overrange();
    test_disabled();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
